// File: rtl/tor_link_arbiter_if.sv
// Link bundle between the NIC ports and the top-of-rack arbiter.
// master = NIC side (drives Tx, observes Rx); slave = switch side.
interface tor_link_arbiter_if #(
  parameter int NUM_PORTS = 2,
  parameter int DATA_W    = 512,
  parameter int ID_W      = 8
);
  // Ingress (NIC Tx) lines, one lane per port
  logic [NUM_PORTS-1:0]        tx_valid;
  logic [NUM_PORTS-1:0]        tx_sop;
  logic [NUM_PORTS-1:0]        tx_eop;
  logic [NUM_PORTS*ID_W-1:0]   tx_dst;
  logic [NUM_PORTS*DATA_W-1:0] tx_data;
  logic [NUM_PORTS-1:0]        tx_ready;

  // Egress (NIC Rx) lines: valid per port, everything else shared
  logic [NUM_PORTS-1:0]        rx_valid;
  logic                        rx_sop;
  logic                        rx_eop;
  logic [ID_W-1:0]             rx_src;
  logic [DATA_W-1:0]           rx_data;

  modport master (
    output tx_valid, tx_sop, tx_eop, tx_dst, tx_data,
    input  tx_ready,
    input  rx_valid, rx_sop, rx_eop, rx_src, rx_data
  );

  modport slave (
    input  tx_valid, tx_sop, tx_eop, tx_dst, tx_data,
    output tx_ready,
    output rx_valid, rx_sop, rx_eop, rx_src, rx_data
  );
endinterface

// File: rtl/tor_link_arbiter.sv
// Emulated top-of-rack switch: round-robin arbitration with packet-level
// grant locking, a LATENCY-deep link delay line, and a per-destination
// egress demux. Packets with an out-of-range destination, and flits that
// arrive without a start-of-packet while idle, are consumed and counted.
// Optional: define TOR_STATS_EN to add per-destination forwarded-packet
// counters on fwd_cnt.
module tor_link_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int DATA_W    = 512,
  parameter int ID_W      = 8,
  parameter int LATENCY   = 1,
  parameter int CNT_W     = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  tor_link_arbiter_if.slave          link,
  output logic [CNT_W-1:0]           drop_cnt
`ifdef TOR_STATS_EN
  ,
  output logic [NUM_PORTS*CNT_W-1:0] fwd_cnt
`endif
);

  localparam int PTR_W = $clog2(NUM_PORTS);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [PTR_W:0]   sum_t;

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  // One delay-line slot; vld is already demuxed one-hot to the destination
  typedef struct packed {
    logic [NUM_PORTS-1:0] vld;
    logic                 sop;
    logic                 eop;
    logic [ID_W-1:0]      src;
    logic [DATA_W-1:0]    data;
  } flit_t;

  // Port following p, wrapping at NUM_PORTS
  function automatic ptr_t next_port(ptr_t p);
    return (p == ptr_t'(NUM_PORTS - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  // (base + off) mod NUM_PORTS for off < NUM_PORTS, without a divider
  function automatic ptr_t wrap_add(ptr_t base, int off);
    sum_t s;
    s = sum_t'(base) + sum_t'(off);
    if (s >= sum_t'(NUM_PORTS)) s = s - sum_t'(NUM_PORTS);
    return s[PTR_W-1:0];
  endfunction

  state_t state;
  ptr_t   rr_ptr;
  ptr_t   owner;
  ptr_t   pkt_dst;
  logic   drop_pkt;

  ptr_t   winner;
  logic   found;
  ptr_t   acc_port;
  logic   acc;

  logic              sel_sop;
  logic              sel_eop;
  logic [ID_W-1:0]   sel_dst;
  logic [DATA_W-1:0] sel_data;
  logic              dst_ok;
  logic              fwd;
  ptr_t              fwd_dst;
  logic              drop_now;
  flit_t             in_flit;
  flit_t             stage [LATENCY];

  // Round-robin scan: first valid port starting at rr_ptr
  always_comb begin
    // NOTE: every combinational output gets a default before any branch,
    // so no path leaves it unassigned and no latch is inferred.
    winner = '0;
    found  = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!found && link.tx_valid[wrap_add(rr_ptr, i)]) begin
        winner = wrap_add(rr_ptr, i);
        found  = 1'b1;
      end
    end
  end

  // Grant: the scan winner while idle, the packet owner while bursting
  always_comb begin
    link.tx_ready = '0;
    acc_port      = winner;
    acc           = 1'b0;
    if (state == IDLE) begin
      link.tx_ready[winner] = found;
      acc                   = found;
    end else begin
      link.tx_ready[owner] = 1'b1;
      acc_port             = owner;
      acc                  = link.tx_valid[owner];
    end
  end

  assign sel_sop  = link.tx_sop[acc_port];
  assign sel_eop  = link.tx_eop[acc_port];
  assign sel_dst  = link.tx_dst[int'(acc_port) * ID_W +: ID_W];
  assign sel_data = link.tx_data[int'(acc_port) * DATA_W +: DATA_W];
  assign dst_ok   = int'(sel_dst) < NUM_PORTS;

  // Forward / drop decision for the flit accepted this cycle
  always_comb begin
    fwd      = 1'b0;
    fwd_dst  = pkt_dst;
    drop_now = 1'b0;
    if (acc) begin
      if (state == IDLE) begin
        // A new packet needs a sop and a reachable destination
        fwd      = sel_sop && dst_ok;
        fwd_dst  = sel_dst[PTR_W-1:0];
        drop_now = !sel_sop || !dst_ok;
      end else begin
        // Mid-packet flits follow the decision made on the sop flit
        fwd = !drop_pkt;
      end
    end
  end

  // Build the flit entering delay stage 0
  always_comb begin
    in_flit.vld = '0;
    if (fwd) in_flit.vld[fwd_dst] = 1'b1;
    in_flit.sop  = sel_sop;
    in_flit.eop  = sel_eop;
    in_flit.src  = ID_W'(acc_port);
    in_flit.data = sel_data;
  end

  // Arbitration FSM: grant locking, round-robin pointer, drop accounting
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state registers use non-blocking assignment so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      pkt_dst  <= '0;
      drop_pkt <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (drop_now && drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
      case (state)
        IDLE: begin
          if (acc) begin
            if (sel_sop && !sel_eop) begin
              state    <= BURST;
              owner    <= winner;
              pkt_dst  <= sel_dst[PTR_W-1:0];
              drop_pkt <= !dst_ok;
            end else begin
              // Single-flit packet or orphan: turn passes on immediately
              rr_ptr <= next_port(winner);
            end
          end
        end
        BURST: begin
          if (acc && sel_eop) begin
            state  <= IDLE;
            rr_ptr <= next_port(owner);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Link delay line; payload only moves with a valid flit so rx_* hold
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: the delay line is reset in full (payload too) because the last
    // stage drives the outputs directly and they must read zero out of reset.
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) stage[i] <= '0;
    end else begin
      if (fwd) stage[0] <= in_flit;
      else     stage[0].vld <= '0;
      for (int i = 1; i < LATENCY; i++) begin
        if (|stage[i-1].vld) stage[i] <= stage[i-1];
        else                 stage[i].vld <= '0;
      end
    end
  end

  assign link.rx_valid = stage[LATENCY-1].vld;
  assign link.rx_sop   = stage[LATENCY-1].sop;
  assign link.rx_eop   = stage[LATENCY-1].eop;
  assign link.rx_src   = stage[LATENCY-1].src;
  assign link.rx_data  = stage[LATENCY-1].data;

`ifdef TOR_STATS_EN
  // Count packets per destination as their eop flit leaves the link
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fwd_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (link.rx_valid[i] && link.rx_eop && fwd_cnt[i*CNT_W +: CNT_W] != '1)
          fwd_cnt[i*CNT_W +: CNT_W] <= fwd_cnt[i*CNT_W +: CNT_W] + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_tor_link_arbiter.sv
// Bench for tor_link_arbiter: two instances (link latency 1 and 4) share
// the same ingress stimulus; a packet-level model predicts grants, drops
// and the egress stream and is compared every cycle, alongside directed
// literal expectations.
module tb_tor_link_arbiter;

  localparam int N  = 2;
  localparam int DW = 32;
  localparam int IW = 8;
  localparam int CW = 16;

  logic clk;
  logic reset;
  logic [N-1:0]    tx_valid;
  logic [N-1:0]    tx_sop;
  logic [N-1:0]    tx_eop;
  logic [N*IW-1:0] tx_dst;
  logic [N*DW-1:0] tx_data;
  logic [CW-1:0]   drop1;
  logic [CW-1:0]   drop4;
`ifdef TOR_STATS_EN
  logic [N*CW-1:0] fwd1;
  logic [N*CW-1:0] fwd4;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  tor_link_arbiter_if #(.NUM_PORTS(N), .DATA_W(DW), .ID_W(IW)) if1 ();
  tor_link_arbiter_if #(.NUM_PORTS(N), .DATA_W(DW), .ID_W(IW)) if4 ();

  assign if1.tx_valid = tx_valid;
  assign if1.tx_sop   = tx_sop;
  assign if1.tx_eop   = tx_eop;
  assign if1.tx_dst   = tx_dst;
  assign if1.tx_data  = tx_data;
  assign if4.tx_valid = tx_valid;
  assign if4.tx_sop   = tx_sop;
  assign if4.tx_eop   = tx_eop;
  assign if4.tx_dst   = tx_dst;
  assign if4.tx_data  = tx_data;

  tor_link_arbiter #(.NUM_PORTS(N), .DATA_W(DW), .ID_W(IW), .LATENCY(1), .CNT_W(CW)) dut1 (
    .clk      (clk),
    .reset    (reset),
    .link     (if1),
    .drop_cnt (drop1)
`ifdef TOR_STATS_EN
    ,
    .fwd_cnt  (fwd1)
`endif
  );

  tor_link_arbiter #(.NUM_PORTS(N), .DATA_W(DW), .ID_W(IW), .LATENCY(4), .CNT_W(CW)) dut4 (
    .clk      (clk),
    .reset    (reset),
    .link     (if4),
    .drop_cnt (drop4)
`ifdef TOR_STATS_EN
    ,
    .fwd_cnt  (fwd4)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [N-1:0]  vec;
    logic          sop;
    logic          eop;
    logic [IW-1:0] src;
    logic [DW-1:0] data;
  } eg_t;

  eg_t sched [int];   // egress flit keyed by the edge on which it was accepted
  eg_t last1, last4;
  bit  m_busy;
  int  m_owner, m_dst, m_rr, m_drop_cnt;
  bit  m_drop;

  function automatic int m_grant(logic [N-1:0] v, int rr);
    for (int k = 0; k < N; k++) begin
      if (v[(rr + k) % N]) return (rr + k) % N;
    end
    return -1;
  endfunction

  function automatic eg_t zero_eg();
    eg_t z;
    z.vec = '0; z.sop = 1'b0; z.eop = 1'b0; z.src = '0; z.data = '0;
    return z;
  endfunction

  always @(negedge clk) begin : model_cmp
    logic [N-1:0]  exp_rdy, e_vec;
    int            g, a, s_dst, d;
    bit            fwd;
    eg_t           e;
    if (reset) begin
      m_busy = 0; m_owner = 0; m_dst = 0; m_rr = 0; m_drop = 0; m_drop_cnt = 0;
      sched.delete();
      last1 = zero_eg();
      last4 = zero_eg();
      check("rst_rx_valid_l1", if1.rx_valid, 0);
      check("rst_rx_valid_l4", if4.rx_valid, 0);
      check("rst_rx_data_l1", if1.rx_data, 0);
      check("rst_drop_l4", drop4, 0);
    end else begin
      // Outputs after the latest edge
      e_vec = '0;
      if (sched.exists(cyc)) begin last1 = sched[cyc]; e_vec = last1.vec; end
      check("rx_valid_l1", if1.rx_valid, e_vec);
      check("rx_sop_l1", if1.rx_sop, last1.sop);
      check("rx_eop_l1", if1.rx_eop, last1.eop);
      check("rx_src_l1", if1.rx_src, last1.src);
      check("rx_data_l1", if1.rx_data, last1.data);
      e_vec = '0;
      if (sched.exists(cyc - 3)) begin last4 = sched[cyc - 3]; e_vec = last4.vec; end
      check("rx_valid_l4", if4.rx_valid, e_vec);
      check("rx_sop_l4", if4.rx_sop, last4.sop);
      check("rx_eop_l4", if4.rx_eop, last4.eop);
      check("rx_src_l4", if4.rx_src, last4.src);
      check("rx_data_l4", if4.rx_data, last4.data);
      check("drop_cnt_l1", drop1, m_drop_cnt);
      check("drop_cnt_l4", drop4, m_drop_cnt);

      // Grant and accept for the upcoming edge
      exp_rdy = '0;
      if (!m_busy) begin
        g = m_grant(tx_valid, m_rr);
        if (g >= 0) exp_rdy[g] = 1'b1;
        a = g;
      end else begin
        exp_rdy[m_owner] = 1'b1;
        a = tx_valid[m_owner] ? m_owner : -1;
      end
      check("tx_ready_l1", if1.tx_ready, exp_rdy);
      check("tx_ready_l4", if4.tx_ready, exp_rdy);

      if (a >= 0) begin
        fwd   = 0;
        d     = 0;
        s_dst = int'(tx_dst[a*IW +: IW]);
        if (!m_busy) begin
          if (!tx_sop[a]) begin
            m_drop_cnt++;
            m_rr = (a + 1) % N;
          end else begin
            if (s_dst >= N) m_drop_cnt++;
            fwd = (s_dst < N);
            d   = s_dst;
            if (tx_eop[a]) m_rr = (a + 1) % N;
            else begin
              m_busy = 1; m_owner = a; m_dst = s_dst; m_drop = (s_dst >= N);
            end
          end
        end else begin
          fwd = !m_drop;
          d   = m_dst;
          if (tx_eop[a]) begin m_busy = 0; m_rr = (m_owner + 1) % N; end
        end
        if (fwd) begin
          e.vec = '0; e.vec[d] = 1'b1;
          e.sop = tx_sop[a]; e.eop = tx_eop[a];
          e.src = IW'(a); e.data = tx_data[a*DW +: DW];
          sched[cyc + 1] = e;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    tx_valid = '0; tx_sop = '0; tx_eop = '0; tx_dst = '0; tx_data = '0;
  endtask

  task automatic set_port(input int p, input logic sop, input logic eop,
                          input int dst, input logic [DW-1:0] data);
    tx_valid[p] = 1'b1;
    tx_sop[p]   = sop;
    tx_eop[p]   = eop;
    tx_dst[p*IW +: IW] = IW'(dst);
    tx_data[p*DW +: DW] = data;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
  endtask

  int eop_seen [N];

  // Drive one flit on port p alone, tallying egress packet ends on the L=1 DUT
  task automatic send_flit(input int p, input logic sop, input logic eop,
                           input int dst, input logic [DW-1:0] data);
    idle();
    set_port(p, sop, eop, dst, data);
    @(negedge clk);
    for (int i = 0; i < N; i++) if (if1.rx_valid[i] && if1.rx_eop) eop_seen[i]++;
    step();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int cnt0, cnt1, repeats, prev;
    logic any_rx;
    reset = 1'b1;
    idle();
    repeat (2) step();
    @(negedge clk);
    check("reset_drop", drop1, 0);
    check("reset_rx_valid", if1.rx_valid, 0);
    step();
    reset = 1'b0;

    // Single flit port0 -> port1
    set_port(0, 1'b1, 1'b1, 1, 32'hA5);
    @(negedge clk);
    check("t1_ready", if1.tx_ready, 2'b01);
    step();
    idle();
    @(negedge clk);
    check("t1_rx_valid", if1.rx_valid, 2'b10);
    check("t1_rx_src", if1.rx_src, 0);
    check("t1_rx_data", if1.rx_data, 32'hA5);
    repeat (3) @(negedge clk);
    check("t1_rx_valid_l4", if4.rx_valid, 2'b10);
    check("t1_rx_data_l4", if4.rx_data, 32'hA5);
    step();

    // Fairness: both ports saturate with single-flit packets from reset
    do_reset();
    cnt0 = 0; cnt1 = 0; repeats = 0; prev = -1;
    set_port(0, 1'b1, 1'b1, 1, 32'h1000);
    set_port(1, 1'b1, 1'b1, 0, 32'h2000);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (if1.tx_ready == 2'b01) begin cnt0++; if (prev == 0) repeats++; prev = 0; end
      if (if1.tx_ready == 2'b10) begin cnt1++; if (prev == 1) repeats++; prev = 1; end
      step();
      tx_data[0*DW +: DW] = 32'h1000 + DW'(i);
      tx_data[1*DW +: DW] = 32'h2000 + DW'(i);
    end
    idle();
    check("rr_count_p0", cnt0, 50);
    check("rr_count_p1", cnt1, 50);
    check("rr_alternate", repeats, 0);
    repeat (2) step();

    // Port1 4-flit packet locks out port0
    set_port(1, 1'b1, 1'b0, 0, 32'h10);
    @(negedge clk);
    check("burst_first_ready", if1.tx_ready, 2'b10);
    step();
    for (int f = 1; f <= 3; f++) begin
      set_port(1, 1'b0, (f == 3), 0, 32'h10 + DW'(f));
      set_port(0, 1'b1, 1'b1, 1, 32'h77);
      @(negedge clk);
      check("burst_lock", if1.tx_ready, 2'b10);
      step();
    end
    tx_valid[1] = 1'b0;
    @(negedge clk);
    check("after_eop_ready", if1.tx_ready, 2'b01);
    check("burst_last_valid", if1.rx_valid, 2'b01);
    check("burst_last_eop", if1.rx_eop, 1'b1);
    check("burst_last_data", if1.rx_data, 32'h13);
    step();
    idle();
    repeat (5) step();

    // 3-flit packet to a nonexistent port, then an orphan flit
    any_rx = 1'b0;
    for (int f = 0; f < 3; f++) begin
      idle();
      set_port(0, (f == 0), (f == 2), 5, 32'hD0 + DW'(f));
      @(negedge clk);
      check("drop_pkt_ready", if1.tx_ready, 2'b01);
      any_rx = any_rx | (|if1.rx_valid) | (|if4.rx_valid);
      step();
    end
    idle();
    repeat (5) begin
      @(negedge clk);
      any_rx = any_rx | (|if1.rx_valid) | (|if4.rx_valid);
      step();
    end
    check("drop_pkt_no_rx", any_rx, 1'b0);
    check("drop_pkt_count", drop1, 1);
    set_port(1, 1'b0, 1'b0, 0, 32'hEE);
    step();
    idle();
    @(negedge clk);
    check("orphan_count", drop1, 2);
    step();

    // Reset mid-packet while flits are still inside the 4-deep link
    set_port(0, 1'b1, 1'b0, 1, 32'h55);
    step();
    set_port(0, 1'b0, 1'b0, 1, 32'h56);
    step();
    idle();
    step();
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    any_rx = 1'b0;
    repeat (6) begin
      @(negedge clk);
      any_rx = any_rx | (|if4.rx_valid);
    end
    check("l4_flushed", any_rx, 1'b0);
    check("l4_drop_after_rst", drop4, 0);
    step();
    set_port(0, 1'b1, 1'b1, 5, 32'h1);
    set_port(1, 1'b1, 1'b1, 5, 32'h2);
    @(negedge clk);
    check("rr_after_rst", if1.tx_ready, 2'b01);
    step();
    idle();

    // Statistics mix: 3 packets to port1 (incl. hairpins), 2 to port0
    do_reset();
    eop_seen[0] = 0; eop_seen[1] = 0;
    send_flit(0, 1'b1, 1'b0, 1, 32'h100);
    send_flit(0, 1'b0, 1'b1, 0, 32'h101);
    send_flit(1, 1'b1, 1'b1, 1, 32'h102);
    send_flit(0, 1'b1, 1'b1, 0, 32'h103);
    send_flit(1, 1'b1, 1'b1, 1, 32'h104);
    send_flit(1, 1'b1, 1'b0, 0, 32'h105);
    send_flit(1, 1'b0, 1'b1, 1, 32'h106);
    idle();
    repeat (8) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) if (if1.rx_valid[i] && if1.rx_eop) eop_seen[i]++;
      step();
    end
    check("pkts_to_p1", eop_seen[1], 3);
    check("pkts_to_p0", eop_seen[0], 2);
`ifdef TOR_STATS_EN
    check("fwd_cnt_l1_p1", fwd1[CW +: CW], 3);
    check("fwd_cnt_l1_p0", fwd1[0 +: CW], 2);
    check("fwd_cnt_l4_p1", fwd4[CW +: CW], 3);
    check("fwd_cnt_l4_p0", fwd4[0 +: CW], 2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
